// File: rtl/ps2_matrix.sv
// ps2_matrix
// PS/2 set-2 keyboard receiver feeding the ZX Spectrum 8x5 key matrix.
// Conditions the raw PS/2 lines, receives and validates 11-bit frames,
// decodes E0/F0 prefixed scan codes into a 40-bit pressed-key register and
// answers the ULA half-row selection on a[15:8] combinationally. It also
// pulses nmi on F5 make and rstReq on Ctrl+Alt+Del.
//
// Optional feature macro: ZXKYP_COMPOSITE_KEYS_EN
//   When defined, the arrow keys and Backspace map to CS plus a digit
//   through a separate composite register. When undefined, those codes are
//   unmapped.
module ps2_matrix #(
    parameter int TIMEOUT = 70000,
    parameter int FILTER  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clock,
    input  logic       ps2Data,
    input  logic [7:0] a,
    output logic [4:0] keys,
    output logic [7:0] code,
    output logic       strobe,
    output logic       nmi,
    output logic       rstReq
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

    // Receiver states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Matrix bit positions used outside the main lookup (row * 5 + column)
    localparam int IDX_CS = 0;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    // Two-flop synchronisers for the asynchronous PS/2 lines
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sync flops reset to the idle-high line level so reset release never fakes a falling edge.
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2Clock;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2Data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: the level follows the synchronised clock only after FILTER equal samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FW'(FILTER - 1)) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // Falling edge of the filtered clock, valid in the cycle the level flips
    assign w_fall = r_clk_filt & ~r_clk_s2 & (r_filt_cnt == FW'(FILTER - 1));

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_tmo;
    logic          w_frame_ok;
    logic [7:0]    w_byte;

    // Serial frame FSM with inter-edge timeout that abandons stalled frames
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par_ok <= 1'b0;
            r_tmo    <= '0;
        end else if (w_fall) begin
            r_tmo <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        r_state  <= ST_DATA;
                        r_bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    r_shift  <= {r_dat_s2, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        r_state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    r_par_ok <= ^{r_shift, r_dat_s2};
                    r_state  <= ST_STOP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_tmo == TW'(TIMEOUT - 1)) begin
                r_state <= ST_IDLE;
                r_tmo   <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_frame_ok = w_fall && (r_state == ST_STOP) && r_dat_s2 && r_par_ok;
    assign w_byte     = r_shift;

    // Last good byte and its one-cycle strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code   <= 8'h00;
            strobe <= 1'b0;
        end else begin
            strobe <= w_frame_ok;
            if (w_frame_ok) begin
                code <= w_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan code decoder
    // ------------------------------------------------------------------
    logic        r_ext;
    logic        r_rel;
    logic        r_ctrl;
    logic        r_alt;
    logic        r_nmi;
    logic        r_rst_req;
    logic [39:0] r_matrix;
    logic [39:0] w_eff;
    logic        w_map_hit;
    logic [5:0]  w_map_idx;
    logic        w_key_byte;
    logic        w_bat;

    assign w_key_byte = w_frame_ok && (w_byte != 8'hE0) && (w_byte != 8'hF0);
    assign w_bat      = w_key_byte && !r_ext && !r_rel && (w_byte == 8'hAA);

    // Scan code to matrix position lookup (row * 5 + column)
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        w_map_hit = 1'b1;
        w_map_idx = 6'd0;
        case ({r_ext, w_byte})
            9'h012, 9'h059: w_map_idx = 6'd0;   // CS
            9'h01A: w_map_idx = 6'd1;           // Z
            9'h022: w_map_idx = 6'd2;           // X
            9'h021: w_map_idx = 6'd3;           // C
            9'h02A: w_map_idx = 6'd4;           // V
            9'h01C: w_map_idx = 6'd5;           // A
            9'h01B: w_map_idx = 6'd6;           // S
            9'h023: w_map_idx = 6'd7;           // D
            9'h02B: w_map_idx = 6'd8;           // F
            9'h034: w_map_idx = 6'd9;           // G
            9'h015: w_map_idx = 6'd10;          // Q
            9'h01D: w_map_idx = 6'd11;          // W
            9'h024: w_map_idx = 6'd12;          // E
            9'h02D: w_map_idx = 6'd13;          // R
            9'h02C: w_map_idx = 6'd14;          // T
            9'h016: w_map_idx = 6'd15;          // 1
            9'h01E: w_map_idx = 6'd16;          // 2
            9'h026: w_map_idx = 6'd17;          // 3
            9'h025: w_map_idx = 6'd18;          // 4
            9'h02E: w_map_idx = 6'd19;          // 5
            9'h045: w_map_idx = 6'd20;          // 0
            9'h046: w_map_idx = 6'd21;          // 9
            9'h03E: w_map_idx = 6'd22;          // 8
            9'h03D: w_map_idx = 6'd23;          // 7
            9'h036: w_map_idx = 6'd24;          // 6
            9'h04D: w_map_idx = 6'd25;          // P
            9'h044: w_map_idx = 6'd26;          // O
            9'h043: w_map_idx = 6'd27;          // I
            9'h03C: w_map_idx = 6'd28;          // U
            9'h035: w_map_idx = 6'd29;          // Y
            9'h05A: w_map_idx = 6'd30;          // ENTER
            9'h04B: w_map_idx = 6'd31;          // L
            9'h042: w_map_idx = 6'd32;          // K
            9'h03B: w_map_idx = 6'd33;          // J
            9'h033: w_map_idx = 6'd34;          // H
            9'h029: w_map_idx = 6'd35;          // SPACE
            9'h014, 9'h114: w_map_idx = 6'd36;  // SS (either Ctrl)
            9'h03A: w_map_idx = 6'd37;          // M
            9'h031: w_map_idx = 6'd38;          // N
            9'h032: w_map_idx = 6'd39;          // B
            default: w_map_hit = 1'b0;
        endcase
    end

    // Prefix tracking, matrix update, Ctrl/Alt flags and host request pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_ctrl    <= 1'b0;
            r_alt     <= 1'b0;
            r_nmi     <= 1'b0;
            r_rst_req <= 1'b0;
            r_matrix  <= '0;
        end else begin
            r_nmi     <= 1'b0;
            r_rst_req <= 1'b0;
            if (w_frame_ok && (w_byte == 8'hE0)) begin
                r_ext <= 1'b1;
            end else if (w_frame_ok && (w_byte == 8'hF0)) begin
                r_rel <= 1'b1;
            end else if (w_key_byte) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
                if (w_bat) begin
                    // Keyboard self-test / hotplug: forget every held key
                    r_matrix <= '0;
                    r_ctrl   <= 1'b0;
                    r_alt    <= 1'b0;
                end else begin
                    if (w_map_hit) begin
                        r_matrix[w_map_idx] <= ~r_rel;
                    end
                    if (w_byte == 8'h14) begin
                        r_ctrl <= ~r_rel;
                    end
                    if (w_byte == 8'h11) begin
                        r_alt <= ~r_rel;
                    end
                    r_nmi     <= !r_ext && !r_rel && (w_byte == 8'h03);
                    r_rst_req <= r_ext && !r_rel && (w_byte == 8'h71) && r_ctrl && r_alt;
                end
            end
        end
    end

    assign nmi    = r_nmi;
    assign rstReq = r_rst_req;

`ifdef ZXKYP_COMPOSITE_KEYS_EN
    // ------------------------------------------------------------------
    // Composite keys: each arrow / Backspace holds CS plus one digit
    // bit 0: left -> 5, 1: down -> 6, 2: up -> 7, 3: right -> 8, 4: bksp -> 0
    // ------------------------------------------------------------------
    logic [4:0] r_comp;
    logic       w_comp_hit;
    logic [2:0] w_comp_idx;

    // Composite key lookup
    always_comb begin
        w_comp_hit = 1'b1;
        w_comp_idx = 3'd0;
        case ({r_ext, w_byte})
            9'h16B: w_comp_idx = 3'd0;
            9'h172: w_comp_idx = 3'd1;
            9'h175: w_comp_idx = 3'd2;
            9'h174: w_comp_idx = 3'd3;
            9'h066: w_comp_idx = 3'd4;
            default: w_comp_hit = 1'b0;
        endcase
    end

    // Composite register kept apart from the real matrix so arrow releases never drop a held Shift
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_comp <= '0;
        end else if (w_key_byte) begin
            if (w_bat) begin
                r_comp <= '0;
            end else if (w_comp_hit) begin
                r_comp[w_comp_idx] <= ~r_rel;
            end
        end
    end

    // Effective matrix: real keys with composite CS and digit bits merged in
    always_comb begin
        w_eff          = r_matrix;
        w_eff[IDX_CS]  = r_matrix[IDX_CS] | (|r_comp);
        w_eff[19]      = r_matrix[19] | r_comp[0];
        w_eff[24]      = r_matrix[24] | r_comp[1];
        w_eff[23]      = r_matrix[23] | r_comp[2];
        w_eff[22]      = r_matrix[22] | r_comp[3];
        w_eff[20]      = r_matrix[20] | r_comp[4];
    end
`else
    assign w_eff = r_matrix;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [4:0] w_keys;

    // Active-low column data: a column reads 0 if any selected half-row has that key held
    always_comb begin
        w_keys = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (w_eff[r*5+c] && !a[r]) begin
                    w_keys[c] = 1'b0;
                end
            end
        end
    end

    assign keys = w_keys;

endmodule

// File: tb/tb_ps2_matrix.sv
// tb_ps2_matrix
// Self-checking bench for ps2_matrix: drives PS/2 frames bit by bit and
// compares the key matrix read path against a key-table model.
// Build with ZXKYP_COMPOSITE_KEYS_EN defined to exercise composite keys.
module tb_ps2_matrix;

    localparam int TIMEOUT = 300;
    localparam int FILTER  = 4;
    localparam int HALF    = 12;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2Clock = 1'b1;
    logic       ps2Data  = 1'b1;
    logic [7:0] a        = 8'hFF;
    logic [4:0] keys;
    logic [7:0] code;
    logic       strobe;
    logic       nmi;
    logic       rstReq;

    ps2_matrix #(.TIMEOUT(TIMEOUT), .FILTER(FILTER)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2Clock (ps2Clock),
        .ps2Data  (ps2Data),
        .a        (a),
        .keys     (keys),
        .code     (code),
        .strobe   (strobe),
        .nmi      (nmi),
        .rstReq   (rstReq)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int nmi_cnt = 0;
    int rst_cnt = 0;
    int strobe_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] last_code = 8'h00;

    // Key model: one bit per matrix position (row * 5 + column)
    bit model [40];

    // Scan codes {ext, byte}: positions 0..39 in row-major order, then right shift and right ctrl
    localparam logic [8:0] KEY_CODES [42] = '{
        9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A,
        9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
        9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
        9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
        9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
        9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
        9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
        9'h029, 9'h014, 9'h03A, 9'h031, 9'h032,
        9'h059, 9'h114
    };

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of each pulse output
    always @(negedge clock) begin
        if (strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_code  = code;
            strobe_cyc = cyc;
        end
        if (nmi)    nmi_cnt = nmi_cnt + 1;
        if (rstReq) rst_cnt = rst_cnt + 1;
    end

    function automatic int key_slot(input int k);
        if (k < 40) return k;
        return (k == 40) ? 0 : 36;
    endfunction

    function automatic logic [4:0] exp_keys(input logic [7:0] sel);
        logic [4:0] k;
        k = 5'b11111;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!sel[r] && model[r*5+c]) k[c] = 1'b0;
        return k;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 40; i++) model[i] = 1'b0;
    endtask

    // Drive frame bits first..last-1 (0 = start, 9 = parity, 10 = stop)
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int first, input int last);
        logic [10:0] fr;
        fr = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = first; i < last; i++) begin
            @(negedge clock);
            ps2Data = fr[i];
            repeat (HALF) @(negedge clock);
            ps2Clock = 1'b0;
            if (i == 10) fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2Clock = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        ps2Data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 0, 11);
        repeat (HALF) @(negedge clock);
    endtask

    task automatic press(input int k);
        if (KEY_CODES[k][8]) send_byte(8'hE0);
        send_byte(KEY_CODES[k][7:0]);
        model[key_slot(k)] = 1'b1;
    endtask

    task automatic release_key(input int k);
        if (KEY_CODES[k][8]) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(KEY_CODES[k][7:0]);
        model[key_slot(k)] = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] sel [3];
        sel[0] = 8'h00; sel[1] = 8'hFF; sel[2] = 8'($urandom);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            a = sel[i];
            #1;
            checks++;
            if (keys !== 5'b11111) begin
                errors++;
                $display("FAIL reset_keys a=%h: got %b expected 11111", a, keys);
            end
        end
        checks++;
        if ({code, strobe, nmi, rstReq} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got code=%h strobe=%b nmi=%b rstReq=%b expected 00/0/0/0",
                     code, strobe, nmi, rstReq);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        repeat (4) @(negedge clock);
    endtask

    task automatic test_frame();
        int s0;
        s0 = strobe_cnt;
        send_byte(8'h1C);
        model[5] = 1'b1;
        checks++;
        if (strobe_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL frame_strobe: got %0d pulse cycles expected 1", strobe_cnt - s0);
        end
        checks++;
        if (code !== 8'h1C || last_code !== 8'h1C) begin
            errors++;
            $display("FAIL frame_code: got %h/%h expected 1c", code, last_code);
        end
        checks++;
        if (strobe_cyc - fall_cyc !== 2 + FILTER) begin
            errors++;
            $display("FAIL frame_latency: got %0d expected %0d", strobe_cyc - fall_cyc, 2 + FILTER);
        end
        a = 8'hFD; #1;
        checks++;
        if (keys !== 5'b11110) begin
            errors++;
            $display("FAIL frame_keys: got %b expected 11110", keys);
        end
    endtask

    task automatic test_release();
        int s0;
        s0 = strobe_cnt;
        release_key(5);
        a = 8'hFD; #1;
        checks++;
        if (keys !== 5'b11111) begin
            errors++;
            $display("FAIL release_keys: got %b expected 11111", keys);
        end
        checks++;
        if (strobe_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL release_strobes: got %0d expected 2", strobe_cnt - s0);
        end
        // A plain make right after proves the release prefix was cleared
        press(5);
        a = 8'hFD; #1;
        checks++;
        if (keys !== 5'b11110) begin
            errors++;
            $display("FAIL release_prefix_clear: got %b expected 11110", keys);
        end
        release_key(5);
    endtask

    task automatic test_shift_z();
        press(0);
        press(1);
        a = 8'hFE; #1;
        checks++;
        if (keys !== 5'b11100) begin
            errors++;
            $display("FAIL shift_z_row: got %b expected 11100", keys);
        end
        a = 8'h00; #1;
        checks++;
        if (keys !== 5'b11100) begin
            errors++;
            $display("FAIL shift_z_all_rows: got %b expected 11100", keys);
        end
    endtask

    task automatic test_bad_frames();
        int s0;
        s0 = strobe_cnt;
        send_bits(8'h1C, 1'b1, 1'b0, 0, 11);
        send_bits(8'h1C, 1'b0, 1'b1, 0, 11);
        repeat (HALF) @(negedge clock);
        checks++;
        if (strobe_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL bad_frame_strobe: got %0d expected 0", strobe_cnt - s0);
        end
        a = 8'h00; #1;
        checks++;
        if (keys !== exp_keys(8'h00)) begin
            errors++;
            $display("FAIL bad_frame_keys: got %b expected %b", keys, exp_keys(8'h00));
        end
    endtask

    task automatic test_timeout();
        int s0;
        // Stall shorter than the timeout: frame still completes (Z again, idempotent)
        s0 = strobe_cnt;
        send_bits(8'h1A, 1'b0, 1'b0, 0, 4);
        repeat (TIMEOUT - 100) @(negedge clock);
        send_bits(8'h1A, 1'b0, 1'b0, 4, 11);
        checks++;
        if (strobe_cnt - s0 !== 1 || code !== 8'h1A) begin
            errors++;
            $display("FAIL short_stall: got %0d strobes code=%h expected 1 strobe code=1a",
                     strobe_cnt - s0, code);
        end
        a = 8'hFE; #1;
        checks++;
        if (keys !== 5'b11100) begin
            errors++;
            $display("FAIL idempotent_make: got %b expected 11100", keys);
        end
        // Stall past the timeout: partial frame dropped, next frame clean
        s0 = strobe_cnt;
        send_bits(8'h5A, 1'b0, 1'b0, 0, 4);
        repeat (TIMEOUT + 50) @(negedge clock);
        send_byte(8'h29);
        model[35] = 1'b1;
        checks++;
        if (strobe_cnt - s0 !== 1 || code !== 8'h29) begin
            errors++;
            $display("FAIL timeout_recover: got %0d strobes code=%h expected 1 strobe code=29",
                     strobe_cnt - s0, code);
        end
        a = 8'h7F; #1;
        checks++;
        if (keys !== 5'b11110) begin
            errors++;
            $display("FAIL timeout_space: got %b expected 11110", keys);
        end
    endtask

    task automatic test_hotkeys();
        int r0, n0;
        r0 = rst_cnt; n0 = nmi_cnt;
        send_byte(8'hE0); send_byte(8'h71);
        checks++;
        if (rst_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL del_without_ctrl_alt: got %0d expected 0", rst_cnt - r0);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h71);
        press(36);
        send_byte(8'h11);
        send_byte(8'hE0); send_byte(8'h71);
        checks++;
        if (rst_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL rstreq_pulse: got %0d high cycles expected 1", rst_cnt - r0);
        end
        a = 8'h7F; #1;
        checks++;
        if (keys !== exp_keys(8'h7F)) begin
            errors++;
            $display("FAIL ctrl_as_ss: got %b expected %b", keys, exp_keys(8'h7F));
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h71);
        send_byte(8'h03);
        checks++;
        if (nmi_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL nmi_pulse: got %0d high cycles expected 1", nmi_cnt - n0);
        end
        send_byte(8'hF0); send_byte(8'h03);
        checks++;
        if (nmi_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL nmi_on_release: got %0d expected 1", nmi_cnt - n0);
        end
        // BAT clears the matrix and the Ctrl flag, so Alt+Del alone must not request reset
        send_byte(8'hAA);
        clear_model();
        a = 8'h00; #1;
        checks++;
        if (keys !== 5'b11111) begin
            errors++;
            $display("FAIL bat_clear: got %b expected 11111", keys);
        end
        send_byte(8'h11);
        send_byte(8'hE0); send_byte(8'h71);
        checks++;
        if (rst_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL bat_clears_ctrl: got %0d expected 1", rst_cnt - r0);
        end
        send_byte(8'hF0); send_byte(8'h11);
    endtask

    task automatic test_random();
        int k;
        logic [7:0] sel;
        for (int it = 0; it < 30; it++) begin
            k = int'($urandom_range(0, 41));
            if ($urandom_range(0, 2) != 0) press(k);
            else release_key(k);
            checks++;
            if (code !== KEY_CODES[k][7:0]) begin
                errors++;
                $display("FAIL random_code it=%0d: got %h expected %h", it, code, KEY_CODES[k][7:0]);
            end
            for (int j = 0; j < 2; j++) begin
                sel = (j == 0) ? 8'($urandom) : ~(8'h01 << $urandom_range(0, 7));
                a = sel; #1;
                checks++;
                if (keys !== exp_keys(sel)) begin
                    errors++;
                    $display("FAIL random_keys it=%0d a=%h: got %b expected %b", it, sel, keys, exp_keys(sel));
                end
            end
        end
    endtask

    task automatic test_composite();
        send_byte(8'hAA);
        clear_model();
        press(0);
        send_byte(8'hE0); send_byte(8'h6B);
`ifdef ZXKYP_COMPOSITE_KEYS_EN
        a = 8'hF7; #1;
        checks++;
        if (keys !== 5'b01111) begin
            errors++;
            $display("FAIL composite_digit: got %b expected 01111", keys);
        end
`else
        a = 8'hF7; #1;
        checks++;
        if (keys !== 5'b11111) begin
            errors++;
            $display("FAIL arrow_unmapped: got %b expected 11111", keys);
        end
`endif
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        a = 8'hF7; #1;
        checks++;
        if (keys !== 5'b11111) begin
            errors++;
            $display("FAIL composite_release_digit: got %b expected 11111", keys);
        end
        a = 8'hFE; #1;
        checks++;
        if (keys !== 5'b11110) begin
            errors++;
            $display("FAIL composite_shift_held: got %b expected 11110", keys);
        end
        release_key(0);
    endtask

    task automatic test_reset_mid();
        int s0;
        press(5);
        send_bits(8'h33, 1'b0, 1'b0, 0, 5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        a = 8'h00; #1;
        checks++;
        if ({keys, code, strobe, nmi, rstReq} !== {5'b11111, 11'h000}) begin
            errors++;
            $display("FAIL mid_reset: got keys=%b code=%h strobe=%b nmi=%b rstReq=%b expected 11111/00/0/0/0",
                     keys, code, strobe, nmi, rstReq);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        clear_model();
        repeat (4) @(negedge clock);
        s0 = strobe_cnt;
        send_byte(8'h1C);
        model[5] = 1'b1;
        checks++;
        if (strobe_cnt - s0 !== 1 || code !== 8'h1C) begin
            errors++;
            $display("FAIL post_reset_frame: got %0d strobes code=%h expected 1 strobe code=1c",
                     strobe_cnt - s0, code);
        end
        a = 8'hFD; #1;
        checks++;
        if (keys !== exp_keys(8'hFD)) begin
            errors++;
            $display("FAIL post_reset_keys: got %b expected %b", keys, exp_keys(8'hFD));
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_release();
        test_shift_z();
        test_bad_frames();
        test_timeout();
        test_hotkeys();
        test_random();
        test_composite();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
